// File: rtl/ddr_axi_port_arbiter.sv
// ddr_axi_port_arbiter: round-robin share of one AXI3 master port between two burst requesters,
// one transaction in flight, grant held until the burst completes.
module ddr_axi_port_arbiter #(
    parameter int                  DATABUS   = 128,
    parameter int                  IDWIDTH   = 16,
    parameter logic [2:0]          SIZE_DATA = 3'b100,
    parameter logic [IDWIDTH-1:0]  ID_BASE   = 16'h0010
) (
    input  logic                   I_aclk,
    input  logic                   I_aresetn,
    input  logic [1:0]             I_req_valid,
    input  logic [1:0]             I_req_we,
    input  logic [31:0]            I_req_addr0,
    input  logic [31:0]            I_req_addr1,
    input  logic [3:0]             I_req_len0,
    input  logic [3:0]             I_req_len1,
    output logic [1:0]             O_req_ready,
    input  logic [DATABUS-1:0]     I_wdata0,
    input  logic [DATABUS-1:0]     I_wdata1,
    input  logic [1:0]             I_wvalid,
    output logic [1:0]             O_wready,
    output logic [DATABUS-1:0]     O_rdata,
    output logic [1:0]             O_rvalid,
    output logic                   O_rlast,
    output logic [1:0]             O_done,
    output logic [1:0]             O_resp,
    output logic [1:0]             O_grant,
    output logic [IDWIDTH-1:0]     O_mst_awid,
    output logic [31:0]            O_mst_awaddr,
    output logic [3:0]             O_mst_awlen,
    output logic [2:0]             O_mst_awsize,
    output logic [1:0]             O_mst_awburst,
    output logic                   O_mst_awvalid,
    input  logic                   I_mst_awready,
    output logic [IDWIDTH-1:0]     O_mst_wid,
    output logic [DATABUS-1:0]     O_mst_wdata,
    output logic [DATABUS/8-1:0]   O_mst_wstrb,
    output logic                   O_mst_wlast,
    output logic                   O_mst_wvalid,
    input  logic                   I_mst_wready,
    input  logic [IDWIDTH-1:0]     I_bid,
    input  logic [1:0]             I_bresp,
    input  logic                   I_bvalid,
    output logic                   O_bready,
    output logic [IDWIDTH-1:0]     O_arid,
    output logic [31:0]            O_araddr,
    output logic [3:0]             O_arlen,
    output logic [2:0]             O_arsize,
    output logic [1:0]             O_arburst,
    output logic                   O_arvalid,
    input  logic                   I_arready,
    input  logic [IDWIDTH-1:0]     I_rid,
    input  logic [DATABUS-1:0]     I_rdata,
    input  logic [1:0]             I_rresp,
    input  logic                   I_rlast,
    input  logic                   I_rvalid,
    output logic                   O_rready
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, REJECT} state_t;
    state_t state, state_nxt;
    logic               last, win, gi, w_hs, r_hs, unused;
    logic [27:0]        win_addr;
    logic [3:0]         win_len, len_q, cnt;
    logic [8:0]         end_beat;
    logic [31:0]        addr_q;
    logic [IDWIDTH-1:0] id_q;
    logic [1:0]         racc, rresp_max;

    assign win       = (&I_req_valid) ? ~last : I_req_valid[1];
    assign win_addr  = win ? I_req_addr1[31:4] : I_req_addr0[31:4];
    assign win_len   = win ? I_req_len1 : I_req_len0;
    // bit 8 set when the burst's last beat lands past the 4KB page
    assign end_beat  = {1'b0, win_addr[7:0]} + {5'b0, win_len};
    assign gi        = O_grant[1];
    assign w_hs      = O_mst_wvalid & I_mst_wready;
    assign r_hs      = O_rready & I_rvalid;
    assign rresp_max = (I_rresp > racc) ? I_rresp : racc;
    assign unused    = ^{I_bid, I_rid, I_req_addr0[3:0], I_req_addr1[3:0]};

    assign O_mst_awid    = id_q;
    assign O_mst_awaddr  = addr_q;
    assign O_mst_awlen   = len_q;
    assign O_mst_awsize  = SIZE_DATA;
    assign O_mst_awburst = 2'b01;
    assign O_mst_wid     = id_q;
    assign O_mst_wdata   = gi ? I_wdata1 : I_wdata0;
    assign O_mst_wstrb   = '1;
    assign O_arid        = id_q;
    assign O_araddr      = addr_q;
    assign O_arlen       = len_q;
    assign O_arsize      = SIZE_DATA;
    assign O_arburst     = 2'b01;
    assign O_rdata       = I_rdata;

    always_comb begin
        state_nxt    = state;
        O_req_ready  = 2'b00;
        O_wready     = 2'b00;
        O_rvalid     = 2'b00;
        O_mst_wvalid = 1'b0;
        O_mst_wlast  = 1'b0;
        O_bready     = 1'b0;
        O_rready     = 1'b0;
        O_rlast      = 1'b0;
        O_done       = 2'b00;
        O_resp       = 2'b00;
        case (state)
            IDLE: if (|I_req_valid && I_aresetn) begin
                O_req_ready = win ? 2'b10 : 2'b01;
                state_nxt   = end_beat[8] ? REJECT : (I_req_we[win] ? WR_ADDR : RD_ADDR);
            end
            WR_ADDR: if (I_mst_awready) state_nxt = WR_DATA;
            WR_DATA: begin
                O_mst_wvalid = I_wvalid[gi];
                O_wready     = I_mst_wready ? O_grant : 2'b00;
                O_mst_wlast  = cnt == len_q;
                if (O_mst_wvalid && I_mst_wready && O_mst_wlast) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                O_bready = 1'b1;
                if (I_bvalid) begin
                    O_done    = O_grant;
                    O_resp    = I_bresp;
                    state_nxt = IDLE;
                end
            end
            RD_ADDR: if (I_arready) state_nxt = RD_DATA;
            RD_DATA: begin
                O_rready = 1'b1;
                O_rvalid = I_rvalid ? O_grant : 2'b00;
                O_rlast  = I_rlast;
                // a short or long burst is reported as SLVERR regardless of rresp
                if (I_rvalid && I_rlast) begin
                    O_done    = O_grant;
                    O_resp    = (cnt != len_q) ? 2'b10 : rresp_max;
                    state_nxt = IDLE;
                end
            end
            REJECT: begin
                O_done    = O_grant;
                O_resp    = 2'b10;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_aclk or negedge I_aresetn) begin
        if (!I_aresetn) begin
            state         <= IDLE;
            last          <= 1'b1;
            O_grant       <= 2'b00;
            addr_q        <= '0;
            len_q         <= '0;
            id_q          <= '0;
            cnt           <= '0;
            racc          <= '0;
            O_mst_awvalid <= 1'b0;
            O_arvalid     <= 1'b0;
        end else begin
            state         <= state_nxt;
            O_mst_awvalid <= state_nxt == WR_ADDR;
            O_arvalid     <= state_nxt == RD_ADDR;
            if (|O_req_ready) begin
                last    <= win;
                O_grant <= win ? 2'b10 : 2'b01;
                addr_q  <= {win_addr, 4'b0};
                len_q   <= win_len;
                id_q    <= ID_BASE + IDWIDTH'(win);
            end else if (state_nxt == IDLE) begin
                O_grant <= 2'b00;
            end
            cnt  <= (state == IDLE) ? 4'd0 : cnt + 4'(w_hs | r_hs);
            racc <= (state == IDLE) ? 2'd0 : (r_hs ? rresp_max : racc);
        end
    end
endmodule
